tx_streamer_block_arbiter: RTL and testbench
============================================

# tx_streamer_block_arbiter

Block-granular round-robin arbiter that shares one `tx_streamer` data input between `g_num_channels` requesters. It sits between the client data sources and the `tx_streamer` `tx_data_i`/`tx_valid_i`/`tx_last_p1_i`/`tx_dreq_o` port. Each block may be prefixed with a channel-identifying header word so the receiving side can demultiplex. A stalled block is terminated with an abort word, so a stalled channel cannot lock the streamer.

## Interface
- `g_num_channels`, 4: number of requesters, 2..8.
- `g_data_width`, 64: word width; must equal the `tx_streamer` `g_data_width`, minimum 24.
- `g_insert_header`, 1: 1 = emit a header word before each block; 0 = no header.
- `g_header_tag`, 16'hB10C: tag placed in bits [`g_data_width`-1 -: 16] of the header word.
- `g_abort_tag`, 16'hDEAD: tag placed in the same bits of the abort word.
- `g_timeout`, 256: idle cycles allowed inside a block before it is aborted, 2..65535.
- `clk` in 1: system clock; same clock as `tx_streamer` `clk_sys_i`.
- `rst_n` in 1: reset; synchronous, active-low; clock `clk`.
- `ch_req_i` in N: channel i has a complete or partial block pending; held until its last word is accepted.
- `ch_data_i` in N*W: channel i word in slice [i*W +: W].
- `ch_valid_i` in N: channel i word valid.
- `ch_last_i` in N: channel i word is the last word of its block.
- `ch_dreq_o` out N: channel i may present a word this cycle.
- `tx_data_o` out W: word to `tx_streamer` `tx_data_i`.
- `tx_valid_o` out 1: to `tx_valid_i`.
- `tx_last_o` out 1: to `tx_last_p1_i`.
- `tx_dreq_i` in 1: from `tx_dreq_o`.
- `grant_o` out N: one-hot grant, all-zero in IDLE.
- `busy_o` out 1: state is not IDLE.
- `abort_cnt_o` out 16: number of aborted blocks since reset; wraps at 65535 → 0.

## Operation
- States: IDLE, HDR, DATA, ABORT.
- **IDLE:**
  - Selects the first channel with `ch_req_i`=1, searching from `rr_ptr` upward modulo N.
  - Sets `grant_o` to that channel and moves to HDR, or to DATA when `g_insert_header`=0.
  - Nothing is requested → stays in IDLE.
- **HDR:**
  - On a cycle with `tx_dreq_i`=1, registers the header word: tag bits = `g_header_tag`, bits [7:0] = channel index, all other bits 0.
  - Header is registered with `tx_valid_o`=1 and `tx_last_o`=0, then the block moves to DATA.
- **DATA:**
  - `ch_dreq_o[g]` = `tx_dreq_i` for the granted channel g (combinational); it is 0 for all other channels.
  - A word is accepted when `ch_valid_i[g]` & `ch_dreq_o[g]`.
  - An accepted word is registered to `tx_data_o`/`tx_last_o` with `tx_valid_o`=1.
  - Accepting a word with `ch_last_i[g]`=1 → IDLE, `rr_ptr` = g+1 mod N, `grant_o` cleared.
  - `ch_valid_i` or `ch_last_i` of non-granted channels are ignored.
- **Timeout:**
  - A 16-bit counter is cleared on entry to DATA and on every accepted word; otherwise it increments in DATA.
  - When the counter reaches `g_timeout`-1 with no word accepted in that cycle → ABORT. `ch_dreq_o` is 0 from that cycle on.
- **ABORT:**
  - On a cycle with `tx_dreq_i`=1, registers the abort word: tag bits = `g_abort_tag`, bits [7:0] = channel index, other bits 0.
  - Abort word is registered with `tx_valid_o`=1 and `tx_last_o`=1; `abort_cnt_o` increments; → IDLE.
  - `rr_ptr` = g+1 mod N after the abort.
  - The aborted channel must drop `ch_req_i` or restart its block; its residual words are simply not requested.
- `tx_valid_o` is 1 only in the cycle after a rising edge at which `tx_dreq_i`=1 and a word was emitted. Otherwise `tx_valid_o`=0 and `tx_last_o`=0.
- `busy_o`=1 in HDR, DATA and ABORT.

## Timing
- **Reset:** `rst_n`=0 at a rising edge gives:
  - state IDLE, `rr_ptr`=0;
  - `tx_valid_o`=0, `tx_last_o`=0, `tx_data_o`=0;
  - `grant_o`=0, `ch_dreq_o`=0, `busy_o`=0;
  - `abort_cnt_o`=0, timeout counter=0.
  - Reset mid-block drops the block silently; no abort word is sent.
- **Latency:**
  - Accepted channel word → `tx_valid_o` one cycle later.
  - `ch_req_i` rise in IDLE → `grant_o` next cycle; header on `tx_valid_o` one cycle after that, provided `tx_dreq_i`=1.
- **Gap between blocks:** at least one IDLE cycle; no back-to-back grant.
- **Request drop:** `ch_req_i[g]` falling during DATA is ignored; only `ch_last_i` or the timeout ends the grant.
- **`tx_dreq_i` low:** while `tx_dreq_i`=0 in DATA, nothing is accepted and the timeout counter still runs.
- **Same-cycle events:** a last-word acceptance in the same cycle the timeout would expire wins; the block ends normally and no abort is sent.
- **Single-word block** (valid & last on the first word): HDR, DATA (1 cycle), IDLE.

## Test plan
- **Reset:** hold `rst_n`=0 with all `ch_req_i`=1 → all outputs 0, `abort_cnt_o`=0.
- **Single channel:** channel 2 sends a 3-word block 0x10,0x11,0x12, `tx_dreq_i`=1 → `tx_valid_o` words are header with [7:0]=2, then 0x10, 0x11, 0x12 with `tx_last_o` only on 0x12. `grant_o`=4'b0100 during the block, `abort_cnt_o`=0.
- **Round-robin:** channels 0, 1, 3 request simultaneously and each block is 2 words → grant order 0, 1, 3, 0, …; blocks never interleave.
- **Backpressure:** toggle `tx_dreq_i` 1/0 every cycle during a 4-word block → all words in order, no duplicates. `ch_dreq_o` mirrors `tx_dreq_i` while the channel is granted.
- **Timeout:** `g_timeout`=16; channel 1 sends 1 word then stalls → abort word `{16'hDEAD, …, 8'h01}` with `tx_last_o`=1; `abort_cnt_o`=1; next requester granted.
- **No header:** `g_insert_header`=0 with single-word blocks from channels 0 and 1 → output is exactly 2 words, each with `tx_last_o`=1.

Source files
------------

// File: rtl/tx_streamer_block_arbiter.sv
// rtl/tx_streamer_block_arbiter.sv - block-granular round-robin arbiter in front of tx_streamer
// Emits an optional channel header per block and an abort word when a granted block stalls.
module tx_streamer_block_arbiter #(
    parameter int          g_num_channels  = 4,
    parameter int          g_data_width    = 64,
    parameter bit          g_insert_header = 1'b1,
    parameter logic [15:0] g_header_tag    = 16'hB10C,
    parameter logic [15:0] g_abort_tag     = 16'hDEAD,
    parameter int          g_timeout       = 256
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [g_num_channels-1:0]              ch_req_i,
    input  logic [g_num_channels*g_data_width-1:0] ch_data_i,
    input  logic [g_num_channels-1:0]              ch_valid_i,
    input  logic [g_num_channels-1:0]              ch_last_i,
    output logic [g_num_channels-1:0]              ch_dreq_o,
    output logic [g_data_width-1:0]                tx_data_o,
    output logic                                   tx_valid_o,
    output logic                                   tx_last_o,
    input  logic                                   tx_dreq_i,
    output logic [g_num_channels-1:0]              grant_o,
    output logic                                   busy_o,
    output logic [15:0]                            abort_cnt_o
);
    localparam int N  = g_num_channels;
    localparam int W  = g_data_width;
    localparam int IW = $clog2(N);
    localparam logic [15:0] TO_LAST = 16'(g_timeout - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_ABORT} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] gidx, gidx_nxt;
    logic [IW-1:0] rr_ptr, rr_ptr_nxt;
    logic [IW-1:0] g_next;
    logic [15:0]   to_cnt, to_cnt_nxt;
    logic [IW-1:0] sel;
    logic          sel_found;
    logic [IW:0]   cand;
    logic          emit, emit_last, abort_done;
    logic [W-1:0]  emit_data, hdr_word, abort_word;
    logic [W-1:0]  ch_word [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_word[i] = ch_data_i[i*W +: W];
    end

    // Descending scan so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N))
                cand = cand - (IW+1)'(N);
            if (ch_req_i[cand[IW-1:0]]) begin
                sel       = cand[IW-1:0];
                sel_found = 1'b1;
            end
        end
    end

    assign g_next = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        hdr_word                = '0;
        hdr_word[W-1 -: 16]     = g_header_tag;
        hdr_word[7:0]           = 8'(gidx);
        abort_word              = '0;
        abort_word[W-1 -: 16]   = g_abort_tag;
        abort_word[7:0]         = 8'(gidx);
    end

    always_comb begin
        state_nxt  = state;
        gidx_nxt   = gidx;
        rr_ptr_nxt = rr_ptr;
        to_cnt_nxt = to_cnt;
        emit       = 1'b0;
        emit_last  = 1'b0;
        emit_data  = ch_word[gidx];
        abort_done = 1'b0;
        ch_dreq_o  = '0;
        case (state)
            S_IDLE: begin
                if (sel_found) begin
                    gidx_nxt   = sel;
                    to_cnt_nxt = '0;
                    state_nxt  = g_insert_header ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                if (tx_dreq_i) begin
                    emit       = 1'b1;
                    emit_data  = hdr_word;
                    to_cnt_nxt = '0;
                    state_nxt  = S_DATA;
                end
            end
            S_DATA: begin
                ch_dreq_o[gidx] = tx_dreq_i;
                // A last-word acceptance takes priority over an expiring timeout.
                if (tx_dreq_i && ch_valid_i[gidx]) begin
                    emit       = 1'b1;
                    emit_data  = ch_word[gidx];
                    emit_last  = ch_last_i[gidx];
                    to_cnt_nxt = '0;
                    if (ch_last_i[gidx]) begin
                        state_nxt  = S_IDLE;
                        rr_ptr_nxt = g_next;
                    end
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_ABORT;
                end else begin
                    to_cnt_nxt = to_cnt + 16'd1;
                end
            end
            S_ABORT: begin
                if (tx_dreq_i) begin
                    emit       = 1'b1;
                    emit_data  = abort_word;
                    emit_last  = 1'b1;
                    abort_done = 1'b1;
                    state_nxt  = S_IDLE;
                    rr_ptr_nxt = g_next;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            gidx        <= '0;
            rr_ptr      <= '0;
            to_cnt      <= '0;
            tx_data_o   <= '0;
            tx_valid_o  <= 1'b0;
            tx_last_o   <= 1'b0;
            abort_cnt_o <= '0;
        end else begin
            state      <= state_nxt;
            gidx       <= gidx_nxt;
            rr_ptr     <= rr_ptr_nxt;
            to_cnt     <= to_cnt_nxt;
            tx_valid_o <= emit;
            tx_last_o  <= emit_last;
            if (emit)
                tx_data_o <= emit_data;
            if (abort_done)
                abort_cnt_o <= abort_cnt_o + 16'd1;
        end
    end

    always_comb begin
        grant_o = '0;
        if (state != S_IDLE)
            grant_o[gidx] = 1'b1;
    end

    assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_tx_streamer_block_arbiter.sv
// tb/tb_tx_streamer_block_arbiter.sv - randomized self-checking bench for tx_streamer_block_arbiter
// A block-level round-robin model predicts the complete output word stream.
module tb_tx_streamer_block_arbiter;
    localparam int N = 4;
    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   ch_req, ch_valid, ch_last, ch_dreq, grant;
    logic [N*W-1:0] ch_data;
    logic [W-1:0]   tx_data;
    logic           tx_valid, tx_last, tx_dreq, busy;
    logic [15:0]    abort_cnt;

    logic [N-1:0]   ch_req_b, ch_valid_b, ch_last_b, ch_dreq_b, grant_b, accb;
    logic [N*W-1:0] ch_data_b;
    logic [W-1:0]   tx_data_b;
    logic           tx_valid_b, tx_last_b, tx_dreq_b, busy_b;
    logic [15:0]    abort_cnt_b;

    tx_streamer_block_arbiter #(.g_num_channels(N), .g_data_width(W), .g_insert_header(1'b1),
                                .g_timeout(16)) dut (
        .clk(clk), .rst_n(rst_n), .ch_req_i(ch_req), .ch_data_i(ch_data), .ch_valid_i(ch_valid),
        .ch_last_i(ch_last), .ch_dreq_o(ch_dreq), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
        .tx_last_o(tx_last), .tx_dreq_i(tx_dreq), .grant_o(grant), .busy_o(busy),
        .abort_cnt_o(abort_cnt));

    tx_streamer_block_arbiter #(.g_num_channels(N), .g_data_width(W), .g_insert_header(1'b0),
                                .g_timeout(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .ch_req_i(ch_req_b), .ch_data_i(ch_data_b),
        .ch_valid_i(ch_valid_b), .ch_last_i(ch_last_b), .ch_dreq_o(ch_dreq_b),
        .tx_data_o(tx_data_b), .tx_valid_o(tx_valid_b), .tx_last_o(tx_last_b),
        .tx_dreq_i(tx_dreq_b), .grant_o(grant_b), .busy_o(busy_b), .abort_cnt_o(abort_cnt_b));

    int total = 0;
    int bad   = 0;

    logic [W:0] src_q   [N][$];
    logic [W:0] exp_ch  [N][$];
    int         blk_len [N][$];
    bit         blk_abt [N][$];
    int         stall_left [N];
    logic [W:0] exp_q [$];
    int         exp_blk_ch [$];
    int         model_rr = 0;
    int         model_aborts = 0;
    int         mode = 0;
    int         noacc = 0;
    logic [N-1:0] acc = '0;
    logic [N-1:0] drop = '0;

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic add_block(input int c, input int n, input int base, input int stall);
        logic [W-1:0] w, hdr, abw;
        hdr = '0; hdr[W-1 -: 16] = 16'hB10C; hdr[7:0] = 8'(c);
        exp_ch[c].push_back({1'b0, hdr});
        for (int j = 0; j < n; j++) begin
            w = (base < 0) ? {$urandom, $urandom} : W'(base + j);
            src_q[c].push_back({j == n - 1, w});
            if (stall < 0 || j < stall)
                exp_ch[c].push_back({(stall < 0 && j == n - 1), w});
        end
        if (stall >= 0) begin
            abw = '0; abw[W-1 -: 16] = 16'hDEAD; abw[7:0] = 8'(c);
            exp_ch[c].push_back({1'b1, abw});
            stall_left[c] = stall;
        end
        blk_len[c].push_back(stall < 0 ? n + 1 : stall + 2);
        blk_abt[c].push_back(stall >= 0);
    endtask

    // Every loaded block keeps its request up, so the order is plain round-robin over channels with work left.
    task automatic schedule();
        int rem [N];
        int left, c, len;
        left = 0;
        for (int i = 0; i < N; i++) begin rem[i] = blk_len[i].size(); left += rem[i]; end
        while (left > 0) begin
            c = -1;
            for (int k = 0; k < N; k++)
                if (c < 0 && rem[(model_rr + k) % N] > 0) c = (model_rr + k) % N;
            len = blk_len[c].pop_front();
            if (blk_abt[c].pop_front()) model_aborts++;
            repeat (len) exp_q.push_back(exp_ch[c].pop_front());
            exp_blk_ch.push_back(c);
            rem[c]--; left--;
            model_rr = (c + 1) % N;
        end
    endtask

    task automatic step();
        logic [W:0] e;
        logic [N-1:0] oh;
        bit frc;
        @(posedge clk); #1;
        for (int c = 0; c < N; c++) begin
            if (acc[c]) begin
                void'(src_q[c].pop_front());
                if (stall_left[c] > 0) stall_left[c]--;
            end
            if (drop[c]) begin src_q[c].delete(); stall_left[c] = -1; end
        end
        drop = '0;
        frc = (noacc >= 6);
        case (mode)
            0: tx_dreq = 1'b1;
            1: tx_dreq = ~tx_dreq;
            default: tx_dreq = frc || ($urandom % 4 != 0);
        endcase
        for (int c = 0; c < N; c++) begin
            if (src_q[c].size() > 0 && stall_left[c] != 0) begin
                ch_req[c]         = 1'b1;
                ch_valid[c]       = (mode != 2) || frc || ($urandom % 4 != 0);
                ch_data[c*W +: W] = src_q[c][0][W-1:0];
                ch_last[c]        = src_q[c][0][W];
            end else begin
                ch_req[c] = 1'b0; ch_valid[c] = 1'b0; ch_last[c] = 1'b0;
                ch_data[c*W +: W] = '0;
            end
        end
        @(negedge clk);
        if (tx_valid) begin
            if (exp_q.size() == 0) begin
                chk("tx_valid_extra", tx_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("tx_word", {tx_last, tx_data}, e);
                if (e[W]) void'(exp_blk_ch.pop_front());
            end
            if (tx_last && tx_data[W-1 -: 16] == 16'hDEAD) drop[tx_data[1:0]] = 1'b1;
        end
        oh = (exp_blk_ch.size() > 0) ? N'(1) << exp_blk_ch[0] : '0;
        if (grant != 0) chk("grant", grant, oh);
        if (ch_dreq != 0) chk("ch_dreq", ch_dreq, tx_dreq ? oh : '0);
        acc = ch_valid & ch_dreq;
        if (|acc) noacc = 0; else noacc++;
    endtask

    task automatic run_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin step(); n++; end
        chk(tag, exp_q.size(), 0);
        repeat (3) step();
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_aborts"}, abort_cnt, model_aborts);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mode  = 0;
        for (int c = 0; c < N; c++) begin src_q[c].delete(); src_q[c].push_back({1'b1, 64'h0}); end
        repeat (4) step();
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_last", tx_last, 1'b0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ch_dreq", ch_dreq, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_abort_cnt", abort_cnt, 0);
        chk("rst_grant_b", grant_b, 0);
        for (int c = 0; c < N; c++) begin src_q[c].delete(); stall_left[c] = -1; end
        step();
        rst_n = 1'b1;
        model_rr = 0;
        model_aborts = 0;
        step();
    endtask

    initial begin
        int nb;
        rst_n = 1'b0; tx_dreq = 1'b1;
        ch_req = '0; ch_valid = '0; ch_last = '0; ch_data = '0;
        ch_req_b = '0; ch_valid_b = '0; ch_last_b = '0; ch_data_b = '0; tx_dreq_b = 1'b1;
        for (int c = 0; c < N; c++) stall_left[c] = -1;

        do_reset();

        mode = 0;
        add_block(2, 3, 'h10, -1);
        schedule();
        run_drain("single", 200);

        do_reset();
        for (int r = 0; r < 2; r++) begin
            add_block(0, 2, -1, -1); add_block(1, 2, -1, -1); add_block(3, 2, -1, -1);
        end
        schedule();
        run_drain("round_robin", 400);

        mode = 1;
        add_block(0, 4, 'h40, -1);
        schedule();
        run_drain("backpressure", 200);

        do_reset();
        add_block(1, 3, 'h20, 1);
        add_block(2, 2, 'h30, -1);
        schedule();
        run_drain("timeout", 300);
        chk("timeout_abort_cnt", abort_cnt, 1);

        mode = 2;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < N; c++)
                for (int b = 0; b < int'($urandom % 3); b++)
                    add_block(c, 1 + int'($urandom % 6), -1, -1);
            schedule();
            run_drain("random", 3000);
        end

        ch_data_b[0 +: W] = 64'hA0;
        ch_data_b[W +: W] = 64'hA1;
        ch_req_b = 4'b0011; ch_valid_b = 4'b0011; ch_last_b = 4'b0011;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid_b) begin
                if (nb == 0) chk("nohdr_w0", {tx_last_b, tx_data_b}, {1'b1, 64'hA0});
                else if (nb == 1) chk("nohdr_w1", {tx_last_b, tx_data_b}, {1'b1, 64'hA1});
                nb++;
            end
            accb = ch_valid_b & ch_dreq_b;
            @(posedge clk); #1;
            ch_req_b &= ~accb; ch_valid_b &= ~accb; ch_last_b &= ~accb;
        end
        chk("nohdr_count", nb, 2);
        chk("nohdr_aborts", abort_cnt_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
